fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: fetch address after reset; bits [1:0] SHALL be zero.
REQ-002 Parameter DEPTH, default 2: instruction buffer entries; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous reset, active-high.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  output  32  word-aligned fetch address.
REQ-008 imem_resp_valid  input  1  response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 imem_resp_data  input  32  fetched instruction word.
REQ-010 redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-011 redirect_pc  input  32  new fetch target; bits [1:0] ignored, treated as 00.
REQ-012 instr_valid  output  1  buffer head holds an instruction.
REQ-013 instr_ready  input  1  decode consumes the head this cycle.
REQ-014 instr  output  32  head instruction word, feeds decode/control and sign-extension.
REQ-015 instr_pc  output  32  address of the head instruction.

Function
REQ-016 A request SHALL be accepted on cycles where imem_req_valid and imem_req_ready are both 1.
REQ-017 imem_req_valid SHALL be 1 iff (outstanding + buffer occupancy) < DEPTH and rst is 0.
REQ-018 Outstanding counter: +1 on accept, -1 on any imem_resp_valid while outstanding > 0; both in one cycle leave it unchanged.
REQ-019 imem_resp_valid with outstanding == 0 SHALL be ignored, with no state change.
REQ-020 Fetch PC SHALL advance by 4 on each accept and wrap from 32'hFFFF_FFFC to 32'h0000_0000.
REQ-021 While imem_req_valid is 1 and the request is not accepted, imem_req_addr SHALL hold its value unless redirect_valid is 1.
REQ-022 A non-stale response SHALL be written to the buffer tail together with its request address; it becomes visible on instr/instr_pc no earlier than the next cycle.
REQ-023 Minimum latency: request accepted in cycle N, response in N+1, instr_valid = 1 in N+2.
REQ-024 instr_valid SHALL equal (occupancy != 0); instr and instr_pc SHALL show the oldest entry.
REQ-025 When instr_valid and instr_ready are both 1, the head SHALL be popped; push and pop in the same cycle leave occupancy unchanged.
REQ-026 The buffer SHALL never overflow; this is guaranteed by REQ-017.
REQ-027 On redirect_valid, the buffer SHALL be flushed, any same-cycle pop discarded, and fetch PC set to {redirect_pc[31:2],2'b00} for the next cycle.
REQ-028 On redirect_valid, the drop counter SHALL be loaded with outstanding-after-this-cycle, which includes a request accepted in the same cycle and excludes a response received in the same cycle.
REQ-029 While drop counter > 0, each response SHALL decrement both the outstanding counter and the drop counter, and SHALL NOT be written to the buffer.
REQ-030 A response arriving in the redirect cycle SHALL be discarded.
REQ-031 Back-to-back redirects: each redirect SHALL reload the drop counter per REQ-028; the last redirect target wins.
REQ-032 State elements: fetch PC, outstanding and drop counters (clog2(DEPTH)+1 bits), and the buffer with head/tail pointers and occupancy. No combinational path from imem_resp_* to instr_*.

Reset
REQ-033 While rst is 1: fetch PC = RESET_PC, outstanding = 0, drop = 0, occupancy = 0; imem_req_valid = 0 and instr_valid = 0; instr and instr_pc SHALL be 0.
REQ-034 The first request SHALL be issued in the first cycle after rst falls, with imem_req_addr = RESET_PC.
REQ-035 Reset mid-operation SHALL abandon all outstanding requests; responses arriving after reset fall SHALL be ignored per REQ-019.

Verification
REQ-036 Reset, then imem_req_ready=1, 1-cycle memory returning addr^32'hA5A5_0000, instr_ready=1 -> instr_pc sequence 0,4,8,... with matching data; first instr_valid 2 cycles after the first accept.
REQ-037 instr_ready=0 for 10 cycles -> occupancy reaches DEPTH, imem_req_valid falls, no entry lost or duplicated; releasing instr_ready resumes the sequence in order.
REQ-038 3-cycle memory latency with 2 outstanding, redirect_pc=32'h0000_0103 -> both stale responses dropped; next instr_pc = 32'h0000_0100.
REQ-039 Redirect in the same cycle as a response and an accept -> that response is dropped, the accepted request's response is dropped, and the sequence restarts at the target.
REQ-040 Start at RESET_PC=32'hFFFF_FFF8 -> instr_pc sequence FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-041 Assert rst with 2 outstanding, then deliver 2 responses after rst falls -> responses ignored; the sequence restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetch requests, tracks
// in-flight requests, buffers in-order responses for decode, and drops
// responses belonging to requests issued before a redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    logic [31:0]   fetch_pc;
    // address of the next non-stale response; responses return in order
    logic [31:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] occupancy;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   buf_data [DEPTH];
    logic [31:0]   buf_pc   [DEPTH];

    logic [CW:0]   inflight;
    logic [31:0]   redirect_tgt;
    logic          accept;
    logic          resp_take;
    logic          push;
    logic          pop;
    logic [CW-1:0] outstanding_nxt;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // request gating, response classification and buffer push/pop strobes
    always_comb begin
        inflight        = {1'b0, outstanding} + {1'b0, occupancy};
        redirect_tgt    = redirect_pc & 32'hFFFF_FFFC;
        imem_req_valid  = !rst && (int'(inflight) < DEPTH);
        imem_req_addr   = fetch_pc;
        accept          = imem_req_valid && imem_req_ready;
        resp_take       = imem_resp_valid && (outstanding != '0);
        push            = resp_take && (drop_cnt == '0) && !redirect_valid;
        instr_valid     = !rst && (occupancy != '0);
        pop             = instr_valid && instr_ready && !redirect_valid;
        outstanding_nxt = outstanding + CW'(accept) - CW'(resp_take);
        instr           = instr_valid ? buf_data[head] : '0;
        instr_pc        = instr_valid ? buf_pc[head]   : '0;
    end

    // fetch PC, in-flight/drop counters and instruction buffer state
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            occupancy   <= '0;
            head        <= '0;
            tail        <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_data[i] <= '0;
                buf_pc[i]   <= '0;
            end
        end else begin
            outstanding <= outstanding_nxt;
            if (redirect_valid) begin
                // everything still in flight after this edge is stale
                fetch_pc  <= redirect_tgt;
                resp_pc   <= redirect_tgt;
                drop_cnt  <= outstanding_nxt;
                occupancy <= '0;
                head      <= '0;
                tail      <= '0;
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (resp_take && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (push) begin
                    buf_data[tail] <= imem_resp_data;
                    buf_pc[tail]   <= resp_pc;
                    tail           <= ptr_next(tail);
                    resp_pc        <= resp_pc + 32'd4;
                end
                if (pop) begin
                    head <= ptr_next(head);
                end
                occupancy <= occupancy + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (RESET_PC 0 and FFFF_FFF8)
// driven by an in-order memory model with settable latency.
module tb_fetch_unit;
    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    wire         req_valid   [2];
    logic        req_ready   [2];
    wire  [31:0] req_addr    [2];
    logic        resp_valid  [2];
    logic [31:0] resp_data   [2];
    logic        redir_valid [2];
    logic [31:0] redir_pc    [2];
    wire         ivalid      [2];
    logic        iready      [2];
    wire  [31:0] instr       [2];
    wire  [31:0] ipc         [2];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [31:0] mq_addr [2][16];
    int          mq_due  [2][16];
    int          mq_wr   [2];
    int          mq_rd   [2];
    int          mq_cnt  [2];
    int          lat     [2];
    logic        chk_en  [2];
    logic [31:0] exp_pc  [2];
    int          consumed[2];
    int          c;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut0 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid[0]), .imem_req_ready(req_ready[0]), .imem_req_addr(req_addr[0]),
        .imem_resp_valid(resp_valid[0]), .imem_resp_data(resp_data[0]),
        .redirect_valid(redir_valid[0]), .redirect_pc(redir_pc[0]),
        .instr_valid(ivalid[0]), .instr_ready(iready[0]), .instr(instr[0]), .instr_pc(ipc[0])
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut1 (
        .clk(clk), .rst(rst),
        .imem_req_valid(req_valid[1]), .imem_req_ready(req_ready[1]), .imem_req_addr(req_addr[1]),
        .imem_resp_valid(resp_valid[1]), .imem_resp_data(resp_data[1]),
        .redirect_valid(redir_valid[1]), .redirect_pc(redir_pc[1]),
        .instr_valid(ivalid[1]), .instr_ready(iready[1]), .instr(instr[1]), .instr_pc(ipc[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, want);
        end
    endtask

    // One clock: check consumed heads against the expected sequence, record
    // accepts, then present the next due response from each memory model.
    task automatic tick();
        logic        acc      [2];
        logic [31:0] acc_addr [2];
        #2;
        for (int k = 0; k < 2; k++) begin
            acc[k]      = req_valid[k] && req_ready[k];
            acc_addr[k] = req_addr[k];
            if (chk_en[k] && ivalid[k] && iready[k] && !redir_valid[k] && !rst) begin
                chk($sformatf("seq_pc%0d", k), ipc[k], exp_pc[k]);
                chk($sformatf("seq_data%0d", k), instr[k], exp_pc[k] ^ K);
                exp_pc[k]   = exp_pc[k] + 32'd4;
                consumed[k] = consumed[k] + 1;
            end
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (acc[k]) begin
                mq_addr[k][mq_wr[k]] = acc_addr[k];
                mq_due[k][mq_wr[k]]  = cyc + lat[k];
                mq_wr[k]  = (mq_wr[k] + 1) % 16;
                mq_cnt[k] = mq_cnt[k] + 1;
            end
        end
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) begin
            if (mq_cnt[k] > 0 && mq_due[k][mq_rd[k]] <= cyc) begin
                resp_valid[k] = 1'b1;
                resp_data[k]  = mq_addr[k][mq_rd[k]] ^ K;
                mq_rd[k]  = (mq_rd[k] + 1) % 16;
                mq_cnt[k] = mq_cnt[k] - 1;
            end else begin
                resp_valid[k] = 1'b0;
                resp_data[k]  = '0;
            end
        end
    endtask

    task automatic drain(input int n);
        req_ready[0] = 1'b0;
        repeat (n) tick();
        chk("drain_empty", 32'(ivalid[0]), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            req_ready[k] = 1'b0; resp_valid[k] = 1'b0; resp_data[k] = '0;
            redir_valid[k] = 1'b0; redir_pc[k] = '0; iready[k] = 1'b0;
            mq_wr[k] = 0; mq_rd[k] = 0; mq_cnt[k] = 0; lat[k] = 1;
            chk_en[k] = 1'b0; exp_pc[k] = '0; consumed[k] = 0;
        end
        repeat (3) tick();
        chk("rst_req_valid0", 32'(req_valid[0]), 32'd0);
        chk("rst_instr_valid0", 32'(ivalid[0]), 32'd0);
        chk("rst_instr0", instr[0], 32'd0);
        chk("rst_instr_pc0", ipc[0], 32'd0);
        chk("rst_req_valid1", 32'(req_valid[1]), 32'd0);

        // basic stream on both instances; dut1 exercises the PC wrap
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req_ready[k] = 1'b1; iready[k] = 1'b1; chk_en[k] = 1'b1;
        end
        exp_pc[0] = 32'h0000_0000;
        exp_pc[1] = 32'hFFFF_FFF8;
        #1;
        chk("first_req_valid", 32'(req_valid[0]), 32'd1);
        chk("first_req_addr0", req_addr[0], 32'h0000_0000);
        chk("first_req_addr1", req_addr[1], 32'hFFFF_FFF8);
        tick();
        chk("lat_n1_invalid", 32'(ivalid[0]), 32'd0);
        tick();
        chk("lat_n2_valid", 32'(ivalid[0]), 32'd1);
        chk("lat_n2_pc", ipc[0], 32'h0000_0000);
        chk("lat_n2_data", instr[0], K);
        repeat (20) tick();
        chk("stream_progress", (consumed[0] >= 10) ? 32'd1 : 32'd0, 32'd1);
        chk("wrap_progress", (consumed[1] >= 3) ? 32'd1 : 32'd0, 32'd1);
        chk_en[1] = 1'b0; req_ready[1] = 1'b0; iready[1] = 1'b0;

        // decode stall fills the buffer and stops fetching
        iready[0] = 1'b0;
        c = consumed[0];
        repeat (10) tick();
        chk("full_instr_valid", 32'(ivalid[0]), 32'd1);
        chk("full_req_stalled", 32'(req_valid[0]), 32'd0);
        iready[0] = 1'b1;
        repeat (12) tick();
        chk("stall_resume", (consumed[0] - c >= 6) ? 32'd1 : 32'd0, 32'd1);

        // redirect with two stale requests in flight, 3-cycle memory
        drain(6);
        lat[0] = 3;
        req_ready[0] = 1'b1;
        tick();
        tick();
        chk("two_outstanding", 32'(req_valid[0]), 32'd0);
        redir_valid[0] = 1'b1; redir_pc[0] = 32'h0000_0103; exp_pc[0] = 32'h0000_0100;
        tick();
        redir_valid[0] = 1'b0;
        chk("redir_addr", req_addr[0], 32'h0000_0100);
        c = consumed[0];
        repeat (15) tick();
        chk("redir_progress", (consumed[0] - c >= 2) ? 32'd1 : 32'd0, 32'd1);

        // back-to-back redirects: last target wins
        redir_valid[0] = 1'b1; redir_pc[0] = 32'h0000_0300; exp_pc[0] = 32'h0000_0300;
        tick();
        redir_pc[0] = 32'h0000_0406; exp_pc[0] = 32'h0000_0404;
        tick();
        redir_valid[0] = 1'b0;
        chk("b2b_addr", req_addr[0], 32'h0000_0404);
        c = consumed[0];
        repeat (20) tick();
        chk("b2b_progress", (consumed[0] - c >= 2) ? 32'd1 : 32'd0, 32'd1);

        // redirect coinciding with a response and an accept
        drain(8);
        lat[0] = 1;
        req_ready[0] = 1'b1;
        tick();
        chk("coinc_req_valid", 32'(req_valid[0]), 32'd1);
        redir_valid[0] = 1'b1; redir_pc[0] = 32'h0000_0200; exp_pc[0] = 32'h0000_0200;
        tick();
        redir_valid[0] = 1'b0;
        chk("coinc_addr", req_addr[0], 32'h0000_0200);
        c = consumed[0];
        repeat (10) tick();
        chk("coinc_progress", (consumed[0] - c >= 3) ? 32'd1 : 32'd0, 32'd1);

        // reset with two outstanding; late responses must be ignored
        drain(6);
        lat[0] = 3;
        req_ready[0] = 1'b1;
        tick();
        tick();
        chk("rst_two_out", 32'(req_valid[0]), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req_ready[0] = 1'b0;
        #1;
        chk("post_rst_req_valid", 32'(req_valid[0]), 32'd1);
        chk("post_rst_req_addr", req_addr[0], 32'h0000_0000);
        tick();
        chk("stale_ignored_a", 32'(ivalid[0]), 32'd0);
        tick();
        chk("stale_ignored_b", 32'(ivalid[0]), 32'd0);
        exp_pc[0] = 32'h0000_0000;
        req_ready[0] = 1'b1;
        c = consumed[0];
        repeat (12) tick();
        chk("post_rst_progress", (consumed[0] - c >= 2) ? 32'd1 : 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
